// File: rtl/jtvigil_rom_arb.sv
// Round-robin arbiter sharing one SDRAM read port between the scr1, scr2 and
// obj ROM fetchers. Each fetcher keeps a one-word tag cache in front of SDRAM.
module jtvigil_rom_arb #(
    parameter logic [21:0] SCR1_BASE = 22'h00_0000,
    parameter logic [21:0] SCR2_BASE = 22'h04_0000,
    parameter logic [21:0] OBJ_BASE  = 22'h0C_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scr1_cs,
    input  logic [16:0] scr1_addr,
    output logic [31:0] scr1_data,
    output logic        scr1_ok,
    input  logic        scr2_cs,
    input  logic [17:0] scr2_addr,
    output logic [31:0] scr2_data,
    output logic        scr2_ok,
    input  logic        obj_cs,
    input  logic [17:0] obj_addr,
    output logic [31:0] obj_data,
    output logic        obj_ok,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [31:0] sdram_din
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    localparam logic [1:0] SCR1 = 2'd0;
    localparam logic [1:0] SCR2 = 2'd1;
    localparam logic [1:0] OBJ  = 2'd2;

    state_t      state, state_next;
    logic [1:0]  rr, grant, pick, first, second;
    logic        found, load, fill;
    logic [2:0]  valid, hit, cand, cs;
    logic [16:0] tag1;
    logic [17:0] tag2, tag3;
    logic [31:0] data1, data2, data3;
    logic [21:0] pick_addr;

    function automatic logic [1:0] next_req(input logic [1:0] r);
        return (r == OBJ) ? SCR1 : r + 2'd1;
    endfunction

    assign cs     = {obj_cs, scr2_cs, scr1_cs};
    assign hit[0] = valid[0] & (scr1_addr == tag1);
    assign hit[1] = valid[1] & (scr2_addr == tag2);
    assign hit[2] = valid[2] & (obj_addr  == tag3);
    assign cand   = cs & ~hit;

    assign scr1_ok   = scr1_cs & hit[0];
    assign scr2_ok   = scr2_cs & hit[1];
    assign obj_ok    = obj_cs  & hit[2];
    assign scr1_data = data1;
    assign scr2_data = data2;
    assign obj_data  = data3;

    // Search starts just after the last requester that received data
    always_comb begin
        first  = next_req(rr);
        second = next_req(first);
        found  = 1'b1;
        pick   = rr;
        if (cand[first])       pick = first;
        else if (cand[second]) pick = second;
        else if (cand[rr])     pick = rr;
        else                   found = 1'b0;
    end

    always_comb begin
        pick_addr = SCR1_BASE + {4'b0, scr1_addr, 1'b0};
        case (pick)
            SCR2:    pick_addr = SCR2_BASE + {3'b0, scr2_addr, 1'b0};
            OBJ:     pick_addr = OBJ_BASE  + {3'b0, obj_addr,  1'b0};
            default: pick_addr = SCR1_BASE + {4'b0, scr1_addr, 1'b0};
        endcase
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        fill       = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    load       = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    if (sdram_rdy) begin
                        fill       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (sdram_rdy) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr         <= OBJ;
            grant      <= SCR1;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                grant      <= pick;
                sdram_req  <= 1'b1;
                sdram_addr <= pick_addr;
            end else if (state == WAIT_ACK && sdram_ack) begin
                sdram_req <= 1'b0;
            end
            if (fill) rr <= grant;
        end
    end

    // Only the granted requester's cache entry is touched by a fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            tag1  <= '0;
            tag2  <= '0;
            tag3  <= '0;
            data1 <= '0;
            data2 <= '0;
            data3 <= '0;
        end else begin
            if (load) begin
                case (pick)
                    SCR1: begin tag1 <= scr1_addr; valid[0] <= 1'b0; end
                    SCR2: begin tag2 <= scr2_addr; valid[1] <= 1'b0; end
                    OBJ:  begin tag3 <= obj_addr;  valid[2] <= 1'b0; end
                    default: ;
                endcase
            end
            if (fill) begin
                case (grant)
                    SCR1: begin data1 <= sdram_din; valid[0] <= 1'b1; end
                    SCR2: begin data2 <= sdram_din; valid[1] <= 1'b1; end
                    OBJ:  begin data3 <= sdram_din; valid[2] <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtvigil_rom_arb.sv
// Self-checking bench for jtvigil_rom_arb: directed scenarios plus randomized
// segments checked against a cache/round-robin reference model.
module tb_jtvigil_rom_arb;
    localparam logic [21:0] SCR1_BASE = 22'h00_0000;
    localparam logic [21:0] SCR2_BASE = 22'h04_0000;
    localparam logic [21:0] OBJ_BASE  = 22'h0C_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scr1_cs = 1'b0, scr2_cs = 1'b0, obj_cs = 1'b0;
    logic [16:0] scr1_addr = '0;
    logic [17:0] scr2_addr = '0, obj_addr = '0;
    logic [31:0] scr1_data, scr2_data, obj_data;
    logic        scr1_ok, scr2_ok, obj_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack, sdram_rdy;
    logic [31:0] sdram_din;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ack_dly = 2, rdy_dly = 2;
    bit          same_cycle = 0, resp_en = 0, late_rdy = 0, use_fixed = 0;
    logic [31:0] fixed_data = '0;
    logic [21:0] req_log[$];

    jtvigil_rom_arb dut (
        .clk(clk), .rst(rst),
        .scr1_cs(scr1_cs), .scr1_addr(scr1_addr), .scr1_data(scr1_data), .scr1_ok(scr1_ok),
        .scr2_cs(scr2_cs), .scr2_addr(scr2_addr), .scr2_data(scr2_data), .scr2_ok(scr2_ok),
        .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        return {10'h2B5, a} ^ {a[15:0], 16'h1F2E};
    endfunction

    function automatic logic [21:0] exp_addr(input int n, input logic [17:0] a);
        case (n)
            0:       return SCR1_BASE + {4'b0, a[16:0], 1'b0};
            1:       return SCR2_BASE + {3'b0, a, 1'b0};
            default: return OBJ_BASE + {3'b0, a, 1'b0};
        endcase
    endfunction

    function automatic logic get_ok(input int n);
        case (n)
            0:       return scr1_ok;
            1:       return scr2_ok;
            default: return obj_ok;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int n);
        case (n)
            0:       return scr1_data;
            1:       return scr2_data;
            default: return obj_data;
        endcase
    endfunction

    task automatic set_req(input int n, input logic c, input logic [17:0] a);
        case (n)
            0:       begin scr1_cs = c; scr1_addr = a[16:0]; end
            1:       begin scr2_cs = c; scr2_addr = a; end
            default: begin obj_cs = c; obj_addr = a; end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int n = 0; n < 3; n++) set_req(n, 1'b0, '0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // SDRAM bank model: acks after ack_dly cycles, returns data rdy_dly later
    initial begin : sdram_model
        int ph, cnt;
        bit chk_drop;
        logic [21:0] cur;
        ph = 0; cnt = 0; chk_drop = 0; cur = '0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
        forever begin
            @(posedge clk);
            #1;
            sdram_ack = 1'b0;
            sdram_rdy = 1'b0;
            if (chk_drop) begin
                chk_drop = 0;
                checks++;
                if (sdram_req !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL req_drop: sdram_req=%b required 0", sdram_req);
                end
            end
            if (!resp_en || rst) begin
                ph = 0;
                if (late_rdy && !rst) begin
                    sdram_rdy = 1'b1;
                    sdram_din = 32'hBAD0_0BAD;
                    late_rdy  = 0;
                end
            end else begin
                case (ph)
                    0: if (sdram_req === 1'b1) begin
                        req_log.push_back(sdram_addr);
                        cur = sdram_addr;
                        cnt = ack_dly;
                        ph  = 1;
                    end
                    1: begin
                        checks++;
                        if (sdram_req !== 1'b1 || sdram_addr !== cur) begin
                            errors++;
                            $display("[TB] FAIL req_hold: req=%b addr=%h required 1/%h",
                                     sdram_req, sdram_addr, cur);
                        end
                        if (cnt > 1) cnt--;
                        else begin
                            sdram_ack = 1'b1;
                            chk_drop  = 1;
                            if (same_cycle) begin
                                sdram_rdy = 1'b1;
                                sdram_din = use_fixed ? fixed_data : mem_word(cur);
                                ph = 0;
                            end else begin
                                cnt = rdy_dly;
                                ph  = 2;
                            end
                        end
                    end
                    default: begin
                        if (cnt > 1) cnt--;
                        else begin
                            sdram_rdy = 1'b1;
                            sdram_din = use_fixed ? fixed_data : mem_word(cur);
                            ph = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        scr1_cs = 1'b1; scr2_cs = 1'b1; obj_cs = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin
            errors++;
            $display("[TB] FAIL reset_sdram: req=%b addr=%h required 0/000000", sdram_req, sdram_addr);
        end
        checks++;
        if ({scr1_ok, scr2_ok, obj_ok} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ok: ok=%b required 000", {scr1_ok, scr2_ok, obj_ok});
        end
        checks++;
        if ({scr1_data, scr2_data, obj_data} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: data=%h required 0", {scr1_data, scr2_data, obj_data});
        end
        do_reset();
    endtask

    task automatic test_single_fill();
        int base, rdy_c, ok_c;
        use_fixed = 1; fixed_data = 32'hDEADBEEF;
        ack_dly = 3; rdy_dly = 4; same_cycle = 0; resp_en = 1;
        base = req_log.size();
        @(posedge clk);
        #2 scr1_addr = 17'h00010; scr1_cs = 1'b1;
        #1;
        checks++;
        if (scr1_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_miss: scr1_ok=%b required 0", scr1_ok);
        end
        rdy_c = -1; ok_c = -1;
        for (int i = 0; i < 40 && ok_c < 0; i++) begin
            @(posedge clk);
            #2;
            if (sdram_rdy) rdy_c = cyc;
            if (scr1_ok) ok_c = cyc;
        end
        checks++;
        if (ok_c < 0 || rdy_c < 0 || ok_c != rdy_c + 1) begin
            errors++;
            $display("[TB] FAIL fill_latency: ok cycle %0d required rdy cycle %0d + 1", ok_c, rdy_c);
        end
        checks++;
        if (req_log.size() != base + 1 || req_log[base] !== 22'h000020) begin
            errors++;
            $display("[TB] FAIL fill_addr: %0d requests, first %h required 1 at 000020",
                     req_log.size() - base, (req_log.size() > base) ? req_log[base] : 22'h0);
        end
        checks++;
        if (scr1_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL fill_data: scr1_data=%h required deadbeef", scr1_data);
        end
    endtask

    task automatic test_hit();
        int base;
        bit saw;
        @(posedge clk);
        #2 scr1_cs = 1'b0;
        #1;
        checks++;
        if (scr1_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hit_cs_low: scr1_ok=%b required 0", scr1_ok);
        end
        base = req_log.size();
        @(posedge clk);
        #2 scr1_cs = 1'b1;
        #1;
        checks++;
        if (scr1_ok !== 1'b1 || scr1_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL hit_ok: ok=%b data=%h required 1/deadbeef", scr1_ok, scr1_data);
        end
        saw = 0;
        repeat (6) begin
            @(posedge clk);
            #2 if (sdram_req) saw = 1;
        end
        checks++;
        if (saw || req_log.size() != base) begin
            errors++;
            $display("[TB] FAIL hit_no_sdram: saw_req=%b new_requests=%0d required 0/0",
                     saw, req_log.size() - base);
        end
        scr1_cs = 1'b0;
        use_fixed = 0;
    endtask

    task automatic test_round_robin();
        int base, okc[3];
        bit bad;
        logic [21:0] ea[3];
        ea[0] = 22'h00000A; ea[1] = 22'h04000E; ea[2] = 22'h0C0012;
        do_reset();
        ack_dly = 2; rdy_dly = 3;
        base = req_log.size();
        @(posedge clk);
        #2;
        set_req(0, 1'b1, 18'h5); set_req(1, 1'b1, 18'h7); set_req(2, 1'b1, 18'h9);
        for (int n = 0; n < 3; n++) okc[n] = -1;
        bad = 0;
        for (int i = 0; i < 150 && (okc[0] < 0 || okc[1] < 0 || okc[2] < 0); i++) begin
            @(posedge clk);
            #2;
            for (int n = 0; n < 3; n++)
                if (get_ok(n)) begin
                    if (okc[n] < 0) okc[n] = cyc;
                    if (get_data(n) !== mem_word(ea[n])) bad = 1;
                end
        end
        checks++;
        if (okc[0] < 0 || okc[1] < 0 || okc[2] < 0 || bad) begin
            errors++;
            $display("[TB] FAIL rr_complete: ok cycles %0d %0d %0d bad_data=%b required all served",
                     okc[0], okc[1], okc[2], bad);
        end
        checks++;
        if (req_log.size() != base + 3) begin
            errors++;
            $display("[TB] FAIL rr_count: %0d requests required 3", req_log.size() - base);
        end else begin
            for (int n = 0; n < 3; n++) begin
                checks++;
                if (req_log[base + n] !== ea[n]) begin
                    errors++;
                    $display("[TB] FAIL rr_order%0d: addr=%h required %h", n, req_log[base + n], ea[n]);
                end
            end
        end
        checks++;
        if (!(okc[0] < okc[1] && okc[1] < okc[2])) begin
            errors++;
            $display("[TB] FAIL rr_ok_order: %0d %0d %0d required increasing", okc[0], okc[1], okc[2]);
        end
        for (int n = 0; n < 3; n++) set_req(n, 1'b0, '0);
    endtask

    task automatic test_addr_change();
        int base;
        bit got;
        ack_dly = 2; rdy_dly = 5;
        base = req_log.size();
        @(posedge clk);
        #2 scr2_addr = 18'h100; scr2_cs = 1'b1;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            #2 if (sdram_ack) got = 1;
        end
        @(posedge clk);
        #2 scr2_addr = 18'h101;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            #2 if (sdram_rdy) got = 1;
        end
        @(posedge clk);
        #2;
        checks++;
        if (!got || scr2_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL chg_ok_low: rdy_seen=%b scr2_ok=%b required 1/0", got, scr2_ok);
        end
        scr2_addr = 18'h100;
        #1;
        checks++;
        if (scr2_ok !== 1'b1 || scr2_data !== mem_word(22'h040200)) begin
            errors++;
            $display("[TB] FAIL chg_old_tag: ok=%b data=%h required 1/%h",
                     scr2_ok, scr2_data, mem_word(22'h040200));
        end
        scr2_addr = 18'h101;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            #2 if (scr2_ok) got = 1;
        end
        checks++;
        if (!got || scr2_data !== mem_word(22'h040202)) begin
            errors++;
            $display("[TB] FAIL chg_refill: ok_seen=%b data=%h required 1/%h",
                     got, scr2_data, mem_word(22'h040202));
        end
        checks++;
        if (req_log.size() != base + 2 || req_log[base] !== 22'h040200 || req_log[base + 1] !== 22'h040202) begin
            errors++;
            $display("[TB] FAIL chg_requests: %0d requests required 040200 then 040202",
                     req_log.size() - base);
        end
    endtask

    task automatic test_reset_midop();
        bit got;
        ack_dly = 10;
        @(posedge clk);
        #2 scr1_addr = 17'h33; scr1_cs = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #2 if (sdram_req) got = 1;
        end
        resp_en = 0;
        rst = 1'b1;
        #1;
        checks++;
        if (!got || sdram_req !== 1'b0 || {scr1_ok, scr2_ok, obj_ok} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL rst_midop: req_seen=%b req=%b ok=%b required 1/0/000",
                     got, sdram_req, {scr1_ok, scr2_ok, obj_ok});
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0; scr1_cs = 1'b0; scr2_cs = 1'b0; late_rdy = 1;
        @(posedge clk);
        @(posedge clk);
        #2 scr1_cs = 1'b1; scr2_cs = 1'b1;
        #1;
        checks++;
        if (scr1_ok !== 1'b0 || scr2_ok !== 1'b0 || sdram_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_late_rdy: ok1=%b ok2=%b req=%b required 0/0/0",
                     scr1_ok, scr2_ok, sdram_req);
        end
        ack_dly = 2; rdy_dly = 2; resp_en = 1;
        got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(posedge clk);
            #2 if (scr1_ok && scr2_ok) got = 1;
        end
        checks++;
        if (!got || scr1_data !== mem_word(22'h000066) || scr2_data !== mem_word(22'h040202)) begin
            errors++;
            $display("[TB] FAIL rst_resume: ok_seen=%b d1=%h d2=%h required 1/%h/%h", got,
                     scr1_data, scr2_data, mem_word(22'h000066), mem_word(22'h040202));
        end
        scr1_cs = 1'b0; scr2_cs = 1'b0;
    endtask

    task automatic test_same_cycle();
        bit got;
        same_cycle = 1; ack_dly = 2;
        @(posedge clk);
        #2 obj_addr = 18'h55; obj_cs = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #2 if (sdram_ack) got = 1;
        end
        checks++;
        if (!got || sdram_rdy !== 1'b1 || obj_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL same_pulse: ack_seen=%b rdy=%b ok=%b required 1/1/0", got, sdram_rdy, obj_ok);
        end
        @(posedge clk);
        #2;
        checks++;
        if (obj_ok !== 1'b1 || obj_data !== mem_word(22'h0C00AA)) begin
            errors++;
            $display("[TB] FAIL same_capture: ok=%b data=%h required 1/%h", obj_ok, obj_data, mem_word(22'h0C00AA));
        end
        scr1_addr = 17'h77; scr1_cs = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #2 if (scr1_ok) got = 1;
        end
        checks++;
        if (!got || req_log[$] !== 22'h0000EE) begin
            errors++;
            $display("[TB] FAIL same_next: ok_seen=%b last_addr=%h required 1/0000ee", got, req_log[$]);
        end
        same_cycle = 0;
        scr1_cs = 1'b0; obj_cs = 1'b0;
    endtask

    task automatic test_random();
        logic        c[3];
        logic [17:0] a[3], la[3];
        bit          lv[3];
        logic [21:0] ea[3];
        logic [21:0] pend[$];
        int          base, misses, unmatched;
        bit          done, bad;
        do_reset();
        for (int n = 0; n < 3; n++) begin lv[n] = 0; la[n] = '0; end
        for (int seg = 0; seg < 25; seg++) begin
            ack_dly = $urandom_range(1, 4);
            rdy_dly = $urandom_range(1, 4);
            same_cycle = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #2;
            pend.delete();
            misses = 0;
            base = req_log.size();
            for (int n = 0; n < 3; n++) begin
                c[n] = ($urandom_range(0, 3) != 0);
                a[n] = 18'($urandom_range(0, 3));
                if ($urandom_range(0, 4) == 0) a[n] = 18'($urandom);
                if (n == 0) a[n][17] = 1'b0;
                ea[n] = exp_addr(n, a[n]);
                set_req(n, c[n], a[n]);
            end
            #1;
            for (int n = 0; n < 3; n++) begin
                logic exp_hit;
                exp_hit = c[n] && lv[n] && (la[n] == a[n]);
                if (c[n] && !exp_hit) begin misses++; pend.push_back(ea[n]); end
                checks++;
                if (get_ok(n) !== exp_hit) begin
                    errors++;
                    $display("[TB] FAIL rnd_hit seg%0d req%0d: ok=%b required %b", seg, n, get_ok(n), exp_hit);
                end
            end
            done = 0; bad = 0;
            for (int i = 0; i < 120 && !done; i++) begin
                @(posedge clk);
                #2;
                done = 1;
                for (int n = 0; n < 3; n++) begin
                    if (get_ok(n) && (!c[n] || get_data(n) !== mem_word(ea[n]))) bad = 1;
                    if (c[n] && !get_ok(n)) done = 0;
                end
            end
            checks++;
            if (!done || bad) begin
                errors++;
                $display("[TB] FAIL rnd_serve seg%0d: done=%b bad=%b required 1/0", seg, done, bad);
            end
            unmatched = 0;
            for (int k = base; k < req_log.size(); k++) begin
                int idx;
                idx = -1;
                for (int j = 0; j < pend.size(); j++)
                    if (idx < 0 && pend[j] == req_log[k]) idx = j;
                if (idx < 0) unmatched++;
                else pend.delete(idx);
            end
            checks++;
            if (req_log.size() - base != misses || unmatched != 0) begin
                errors++;
                $display("[TB] FAIL rnd_traffic seg%0d: %0d requests (%0d unexpected) required %0d",
                         seg, req_log.size() - base, unmatched, misses);
            end
            for (int n = 0; n < 3; n++)
                if (c[n]) begin lv[n] = 1; la[n] = a[n]; end
        end
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_hit();
        test_round_robin();
        test_addr_change();
        test_reset_midop();
        test_same_cycle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end
endmodule
